// File: rtl/t05_hist_pkg.sv
// Shared definitions for the histogram reader: scan FSM encoding, table
// geometry, and the end-of-file symbol shared with the histogram builder.
package t05_hist_pkg;

  localparam int HIST_ADDR_W = 8;
  localparam int HIST_DATA_W = 32;
  localparam int HIST_DEPTH  = 256;

  // End-of-file marker symbol; the builder counts it like any other byte.
  localparam logic [HIST_ADDR_W-1:0] HIST_EOF_CHAR = 8'h1A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_EVAL  = 3'd2,
    ST_OUT   = 3'd3,
    ST_CLEAR = 3'd4,
    ST_ADV   = 3'd5,
    ST_FIN   = 3'd6
  } hist_rd_state_t;

endpackage

// File: rtl/t05_hist_reader.sv
// Histogram reader: walks every SRAM entry in ascending order, emits one
// (symbol, frequency) beat per nonzero entry on a valid/ready stream, and
// checks that the emitted frequencies add up to the builder's byte total.
// Build option: define T05_HIST_CLEAR_EN to zero each nonzero entry after
// its beat is accepted, leaving the SRAM ready for the next file.
module t05_hist_reader
  import t05_hist_pkg::*;
#(
  parameter int ADDR_W = HIST_ADDR_W,
  parameter int DATA_W = HIST_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] total_i,
  output logic              sram_req,
  output logic              sram_wr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ack,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [ADDR_W-1:0] sym_char,
  output logic [DATA_W-1:0] sym_freq,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   nonzero_cnt,
  output logic              sum_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  hist_rd_state_t    r_state;
  hist_rd_state_t    w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_freq;
  logic [DATA_W-1:0] r_sum;
  logic [ADDR_W:0]   r_nonzero_cnt;
  logic              r_sum_err;
  logic              w_last;

  assign w_last = (r_addr == LAST_ADDR);

  // Next-state logic for the scan sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_REQ;
      ST_REQ:  if (sram_ack) w_state_next = ST_EVAL;
      ST_EVAL: w_state_next = (r_freq == '0) ? ST_ADV : ST_OUT;
`ifdef T05_HIST_CLEAR_EN
      ST_OUT:   if (sym_ready) w_state_next = ST_CLEAR;
      ST_CLEAR: if (sram_ack) w_state_next = ST_ADV;
`else
      ST_OUT:   if (sym_ready) w_state_next = ST_ADV;
`endif
      ST_ADV:  w_state_next = w_last ? ST_FIN : ST_REQ;
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any scan at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Address, read data, running sum and end-of-scan status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr        <= '0;
      r_freq        <= '0;
      r_sum         <= '0;
      r_nonzero_cnt <= '0;
      r_sum_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr        <= '0;
            r_sum         <= '0;
            r_nonzero_cnt <= '0;
            r_sum_err     <= 1'b0;
          end
        end
        ST_REQ: begin
          if (sram_ack) r_freq <= sram_rdata;
        end
        ST_OUT: begin
          // Sum wraps modulo 2^DATA_W, matching the builder's total counter.
          if (sym_ready) begin
            r_sum         <= r_sum + r_freq;
            r_nonzero_cnt <= r_nonzero_cnt + (ADDR_W+1)'(1);
          end
        end
        ST_ADV: begin
          // The final entry goes to FIN instead, so addr never wraps mid-scan.
          if (!w_last) r_addr <= r_addr + ADDR_W'(1);
        end
        ST_FIN: begin
          r_sum_err <= (r_sum != total_i);
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the state; all fall to 0 on reset.
`ifdef T05_HIST_CLEAR_EN
  assign sram_req = (r_state == ST_REQ) || (r_state == ST_CLEAR);
  assign sram_wr  = (r_state == ST_CLEAR);
`else
  assign sram_req = (r_state == ST_REQ);
  assign sram_wr  = 1'b0;
`endif
  assign sram_addr   = r_addr;
  assign sram_wdata  = '0;
  assign sym_valid   = (r_state == ST_OUT);
  assign sym_char    = r_addr;
  assign sym_freq    = r_freq;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FIN);
  assign nonzero_cnt = r_nonzero_cnt;
  assign sum_err     = r_sum_err;

endmodule
